// File: rtl/banco_registradores_wb_if.sv
// banco_registradores_wb_if: bus between control/memory stage (master) and the write-back register file (slave)
// master drives estado, regwrite, memtoreg, rs1/rs2/rd, writedataR, reddataM, pc_plus4, imm_u, dbg_addr
// slave drives readdata1R, readdata2R, wb_value, wb_done, instret, dbg_data
interface banco_registradores_wb_if;
  logic [3:0]  estado;
  logic        regwrite;
  logic [1:0]  memtoreg;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] writedataR;
  logic [31:0] reddataM;
  logic [31:0] pc_plus4;
  logic [31:0] imm_u;
  logic [31:0] readdata1R;
  logic [31:0] readdata2R;
  logic [31:0] wb_value;
  logic        wb_done;
  logic [31:0] instret;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  modport master (
    output estado, regwrite, memtoreg, rs1, rs2, rd, writedataR, reddataM, pc_plus4, imm_u, dbg_addr,
    input  readdata1R, readdata2R, wb_value, wb_done, instret, dbg_data
  );
  modport slave (
    input  estado, regwrite, memtoreg, rs1, rs2, rd, writedataR, reddataM, pc_plus4, imm_u, dbg_addr,
    output readdata1R, readdata2R, wb_value, wb_done, instret, dbg_data
  );
endinterface

// File: rtl/banco_registradores_wb.sv
// banco_registradores_wb: write-back select/commit, 32x32 register file, operand latch, retired counter, debug read
// ports: clk, rst (sync, active-high), bus (slave modport of banco_registradores_wb_if)
module banco_registradores_wb #(
  parameter logic [3:0] EST_DEC     = 4'b0001,
  parameter logic [3:0] EST_WB_LOAD = 4'b0100,
  parameter logic [3:0] EST_WB_ALU  = 4'b1000
) (
  input  logic                          clk,
  input  logic                          rst,
  banco_registradores_wb_if.slave       bus
);
  logic [31:0] x_q [32];
  logic [31:0] rd1_q, rd2_q, wb_value_q, instret_q;
  logic        wb_done_q;
  logic        commit;
  logic        is_load;
  logic [31:0] v_d;
  always_comb begin
    is_load = bus.estado == EST_WB_LOAD;
    commit  = bus.regwrite && (is_load || bus.estado == EST_WB_ALU);
    // loads always write back memory data, whatever memtoreg says
    v_d = is_load                 ? bus.reddataM :
          bus.memtoreg == 2'b00   ? bus.writedataR :
          bus.memtoreg == 2'b01   ? bus.reddataM :
          bus.memtoreg == 2'b10   ? bus.pc_plus4 : bus.imm_u;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) x_q[i] <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      wb_value_q <= '0;
      wb_done_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      wb_done_q <= commit;
      if (bus.estado == EST_DEC) begin
        rd1_q <= bus.rs1 == 5'd0 ? '0 : x_q[bus.rs1];
        rd2_q <= bus.rs2 == 5'd0 ? '0 : x_q[bus.rs2];
      end
      if (commit) begin
        if (bus.rd != 5'd0) x_q[bus.rd] <= v_d;
        wb_value_q <= v_d;
        instret_q  <= instret_q + 32'd1;
      end
    end
  end
  assign bus.readdata1R = rd1_q;
  assign bus.readdata2R = rd2_q;
  assign bus.wb_value   = wb_value_q;
  assign bus.wb_done    = wb_done_q;
  assign bus.instret    = instret_q;
  assign bus.dbg_data   = bus.dbg_addr == 5'd0 ? '0 : x_q[bus.dbg_addr];
endmodule

// File: doc/banco_registradores_wb.md
Name: banco_registradores_wb

Overview:
- Write-back stage plus 32x32 integer register file for the multicycle RISC-V datapath. Sits directly downstream of the data-memory stage.
- Consumes the memory stage's load data (reddataM) and forwarded ALU result (writedataR). Selects the write-back value and commits it to rd in the write-back states.
- Latches rs1/rs2 operands in the decode state for the execute stage and the memory stage's store data (readdata2R).
- Also provides a retired-instruction counter and a debug read port for FPGA display.

Parameters:
- EST_DEC, 4'b0001, estado value in which rs1/rs2 operands are latched
- EST_WB_LOAD, 4'b0100, estado value of load write-back
- EST_WB_ALU, 4'b1000, estado value of R/I/JAL/LUI write-back

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- estado  input  4  current control FSM state
- regwrite  input  1  register write enable from control
- memtoreg  input  2  write-back select: 00 writedataR, 01 reddataM, 10 pc_plus4, 11 imm_u
- rs1  input  5  source register 1 index
- rs2  input  5  source register 2 index
- rd  input  5  destination register index
- writedataR  input  32  ALU result forwarded by memory stage
- reddataM  input  32  load data from memory stage
- pc_plus4  input  32  return address for JAL/JALR
- imm_u  input  32  pre-shifted U-type immediate (LUI)
- readdata1R  output  32  latched rs1 operand
- readdata2R  output  32  latched rs2 operand; also store data for memory stage
- wb_value  output  32  registered copy of last committed write-back value
- wb_done  output  1  one-cycle pulse after each commit
- instret  output  32  retired write-back count
- dbg_addr  input  5  debug read index
- dbg_data  output  32  combinational read of register dbg_addr

Behaviour:
- Reset (rst=1 at a rising edge) clears all 32 registers, readdata1R, readdata2R, wb_value, wb_done and instret to 0.
- Reset has priority over every other action in that cycle, including a write-back that is mid-commit.
- Storage: reg [31:0] x[0:31]. x0 always reads 0. Writes to rd=0 are discarded but still counted as retired.
- Operand latch:
  - On the rising edge with estado==EST_DEC: readdata1R<=x[rs1], readdata2R<=x[rs2] (0 if the index is 0).
  - Both outputs hold their value in all other states.
- Write-back commit: occurs on the rising edge where estado is EST_WB_LOAD or EST_WB_ALU and regwrite=1.
  - Write value v selected by memtoreg: 00 writedataR, 01 reddataM, 10 pc_plus4, 11 imm_u.
  - In EST_WB_LOAD the value is always reddataM, regardless of memtoreg.
  - Actions on that edge: x[rd]<=v (if rd!=0), wb_value<=v, wb_done<=1, instret<=instret+1.
- wb_done is 0 on every edge that is not a commit edge, so it is a single-cycle pulse.
- regwrite=0 in a WB state: no register update, no wb_done pulse, no instret increment.
- regwrite=1 outside the WB states: ignored.
- instret is a 32-bit counter and wraps 32'hFFFFFFFF -> 0 with no flag.
- Write/read collision:
  - If a commit edge and an EST_DEC edge coincide (not possible with a legal single estado; no special handling), the latched operand takes the old value.
  - dbg_data is purely combinational from the array and shows the new value from the cycle after the commit edge.
- Widths: all data paths 32 bits, no extension or truncation. Indices are 5 bits and fully decoded.
- Latency: commit visible in dbg_data and on the next EST_DEC latch one cycle after the commit edge. wb_done and wb_value are valid in the cycle after the commit edge.

Test Plan:
- Reset: assert rst 1 cycle after random writes -> readdata1R=readdata2R=0, instret=0, wb_done=0, dbg_data=0 for all 32 dbg_addr values.
- ALU write-back: EST_WB_ALU, regwrite=1, memtoreg=00, rd=5, writedataR=32'h0000_002A -> next cycle dbg_addr=5 gives 32'h2A, wb_done=1 for exactly 1 cycle, instret=1. Then EST_DEC with rs1=5, rs2=0 -> readdata1R=32'h2A, readdata2R=0.
- Load and x0:
  - EST_WB_LOAD, rd=7, reddataM=32'hDEAD_BEEF, memtoreg=00 -> x7=32'hDEADBEEF.
  - Then rd=0 with writedataR=32'h1234 -> x0 still reads 0, instret increments to 2.
- JAL/LUI selects: memtoreg=10, pc_plus4=32'h0000_0010, rd=1 -> x1=32'h10. memtoreg=11, imm_u=32'h1234_5000, rd=2 -> x2=32'h12345000. wb_value tracks each commit.
- Gating: regwrite=0 in EST_WB_ALU, and regwrite=1 in estado=4'b0011 -> no register change, no wb_done, instret unchanged.
- Wrap and reset mid-operation:
  - Force instret=32'hFFFF_FFFF, then commit -> instret=0.
  - Assert rst on the same edge as a commit to rd=9 -> x9=0, wb_done=0, instret=0.
